// File: rtl/sprite_fetcher_pkg.sv
// Shared definitions for the sprite fetcher: FSM state encodings, the object
// pixel layout stored in each FIFO slot, and the palette selection helper.
package sprite_fetcher_pkg;

  localparam int OBJ_FIFO_DEPTH = 8;
  localparam int OBJ_PIX_W      = 10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_C1    = 3'd1,
    S_RD_LO = 3'd2,
    S_RD_HI = 3'd3,
    S_MERGE = 3'd4,
    S_DONE  = 3'd5
  } fetch_state_t;

  // {slot[3:0], prio, pal[2:0], colour[1:0]}
  typedef struct packed {
    logic [3:0] slot;
    logic       prio;
    logic [2:0] pal;
    logic [1:0] colour;
  } obj_pix_t;

  function automatic logic [2:0] obj_pal(input logic [7:0] attr, input logic is_gbc);
    return is_gbc ? attr[2:0] : {2'b00, attr[4]};
  endfunction

endpackage

// File: rtl/sprite_fetcher_pix_fifo.sv
// Object pixel FIFO: an 8-slot shift register with a parallel conditional
// merge port and a single-pixel pop.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clr          clear every slot to transparent (wins over shift/merge)
//   shift        pop the head pixel; tail refills transparent
//   merge_en     merge new_row into the (already shifted) FIFO
//   is_gbc       selects CGB priority (lower OAM slot wins) vs DMG (first wins)
//   new_row      candidate pixels, index 0 = leftmost
//   head         current slot 0 contents
module sprite_fetcher_pix_fifo
  import sprite_fetcher_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clr,
  input  logic                           shift,
  input  logic                           merge_en,
  input  logic                           is_gbc,
  input  obj_pix_t [OBJ_FIFO_DEPTH-1:0]  new_row,
  output obj_pix_t                       head
);

  logic [OBJ_FIFO_DEPTH-1:0][OBJ_PIX_W-1:0] slot_q;
  logic [OBJ_FIFO_DEPTH-1:0][OBJ_PIX_W-1:0] shifted;
  logic [OBJ_FIFO_DEPTH-1:0][OBJ_PIX_W-1:0] slot_d;
  obj_pix_t cur;
  obj_pix_t nw;

  // Shift is resolved first so a merge lands on the post-pop alignment.
  always_comb begin
    shifted = slot_q;
    slot_d  = '0;
    cur     = '0;
    nw      = '0;
    if (shift) begin
      for (int i = 0; i < OBJ_FIFO_DEPTH - 1; i++) begin
        shifted[i] = slot_q[i+1];
      end
      shifted[OBJ_FIFO_DEPTH-1] = '0;
    end
    slot_d = shifted;
    if (merge_en) begin
      for (int i = 0; i < OBJ_FIFO_DEPTH; i++) begin
        cur = obj_pix_t'(shifted[i]);
        nw  = new_row[i];
        if ((nw.colour != 2'd0) &&
            ((cur.colour == 2'd0) || (is_gbc && (nw.slot < cur.slot)))) begin
          slot_d[i] = nw;
        end
      end
    end
    if (clr) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign head = obj_pix_t'(slot_q[0]);

endmodule

// File: rtl/sprite_fetcher.sv
// Sprite fetcher: responder side of the OAM evaluator's fetch handshake.
// Reads both tile planes from VRAM, flips/merges the 8-pixel row into the
// object pixel FIFO, and presents the FIFO head to the BG/OBJ mixer.
// Ports:
//   clk, reset, ce            clock, async active-high reset, dot enable
//   isGBC, lcd_on, line_reset mode select, synchronous abort/clear sources
//   sprite_fetch/addr/attr/index   request from the evaluator
//   sprite_fetch_c1/done, sprite_busy   handshake responses
//   vram_rd/addr/bank, vram_data   VRAM read port
//   shift                     mixer pop request
//   spr_pix_color/pal/prio    FIFO head pixel
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for sprite_fetch
// C1      | acknowledge strobe; evaluator latches tile/attr
// RD_LO   | reading low plane byte for RD_CYCLES ce cycles
// RD_HI   | reading high plane byte for RD_CYCLES ce cycles
// MERGE   | flipped row merged into the pixel FIFO
// DONE    | completion strobe, then back to IDLE
module sprite_fetcher
  import sprite_fetcher_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int RD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        isGBC,
  input  logic        lcd_on,
  input  logic        line_reset,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  input  logic [3:0]  sprite_index,
  output logic        sprite_fetch_c1,
  output logic        sprite_fetch_done,
  output logic        sprite_busy,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  input  logic [7:0]  vram_data,
  input  logic        shift,
  output logic [1:0]  spr_pix_color,
  output logic [2:0]  spr_pix_pal,
  output logic        spr_pix_prio
);

  localparam logic [1:0] RD_LOAD = 2'(RD_CYCLES - 1);

  fetch_state_t state_q, state_d;
  logic [1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] lo_q, lo_d, hi_q, hi_d;
  logic       merge_en;
  logic       abort_all;
  obj_pix_t [FIFO_DEPTH-1:0] new_row;
  obj_pix_t   head;
  logic [2:0] sel;

  assign abort_all = ce & (~lcd_on | line_reset);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  end

  // Dropping sprite_fetch before DONE abandons the sprite without touching the FIFO.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    merge_en = 1'b0;
    if (abort_all) begin
      state_d  = S_IDLE;
      rd_cnt_d = '0;
    end else if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          if (sprite_fetch) state_d = S_C1;
        end
        S_C1: begin
          if (!sprite_fetch) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_RD_LO;
            rd_cnt_d = RD_LOAD;
          end
        end
        S_RD_LO: begin
          if (!sprite_fetch) begin
            state_d = S_IDLE;
          end else if (rd_cnt_q == 2'd0) begin
            lo_d     = vram_data;
            state_d  = S_RD_HI;
            rd_cnt_d = RD_LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q - 2'd1;
          end
        end
        S_RD_HI: begin
          if (!sprite_fetch) begin
            state_d = S_IDLE;
          end else if (rd_cnt_q == 2'd0) begin
            hi_d    = vram_data;
            state_d = S_MERGE;
          end else begin
            rd_cnt_d = rd_cnt_q - 2'd1;
          end
        end
        S_MERGE: begin
          if (!sprite_fetch) begin
            state_d = S_IDLE;
          end else begin
            merge_en = 1'b1;
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sprite_fetch_c1   = (state_q == S_C1);
    sprite_fetch_done = (state_q == S_DONE);
    vram_rd           = (state_q == S_RD_LO) || (state_q == S_RD_HI);
    vram_addr         = '0;
    vram_bank         = 1'b0;
    if (vram_rd) begin
      vram_addr = {1'b0, sprite_addr, (state_q == S_RD_HI)};
      vram_bank = sprite_attr[3] & isGBC;
    end
  end

  assign sprite_busy = (state_q != S_IDLE) | sprite_fetch;

  // Pixel 0 is leftmost; without x-flip it comes from the MSB of each plane.
  always_comb begin
    new_row = '0;
    sel     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      sel = sprite_attr[5] ? 3'(i) : 3'(FIFO_DEPTH - 1 - i);
      new_row[i].colour = {hi_q[sel], lo_q[sel]};
      new_row[i].pal    = obj_pal(sprite_attr, isGBC);
      new_row[i].prio   = sprite_attr[7];
      new_row[i].slot   = sprite_index;
    end
  end

  sprite_fetcher_pix_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clr      (abort_all),
    .shift    (shift & ce),
    .merge_en (merge_en),
    .is_gbc   (isGBC),
    .new_row  (new_row),
    .head     (head)
  );

  assign spr_pix_color = head.colour;
  assign spr_pix_pal   = head.pal;
  assign spr_pix_prio  = head.prio;

  // Y-flip is already folded into sprite_addr; the stored slot only feeds the merge compare.
  logic unused_bits;
  assign unused_bits = ^{sprite_attr[6], head.slot};

endmodule

// File: tb/tb_sprite_fetcher.sv
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        isGBC;
  logic        lcd_on;
  logic        line_reset;
  logic        sprite_fetch;
  logic [10:0] sprite_addr;
  logic [7:0]  sprite_attr;
  logic [3:0]  sprite_index;
  logic        sprite_fetch_c1;
  logic        sprite_fetch_done;
  logic        sprite_busy;
  logic        vram_rd;
  logic [12:0] vram_addr;
  logic        vram_bank;
  logic [7:0]  vram_data;
  logic        shift;
  logic [1:0]  spr_pix_color;
  logic [2:0]  spr_pix_pal;
  logic        spr_pix_prio;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_fetcher dut (
    .clk               (clk),
    .reset             (reset),
    .ce                (ce),
    .isGBC             (isGBC),
    .lcd_on            (lcd_on),
    .line_reset        (line_reset),
    .sprite_fetch      (sprite_fetch),
    .sprite_addr       (sprite_addr),
    .sprite_attr       (sprite_attr),
    .sprite_index      (sprite_index),
    .sprite_fetch_c1   (sprite_fetch_c1),
    .sprite_fetch_done (sprite_fetch_done),
    .sprite_busy       (sprite_busy),
    .vram_rd           (vram_rd),
    .vram_addr         (vram_addr),
    .vram_bank         (vram_bank),
    .vram_data         (vram_data),
    .shift             (shift),
    .spr_pix_color     (spr_pix_color),
    .spr_pix_pal       (spr_pix_pal),
    .spr_pix_prio      (spr_pix_prio)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the VRAM side until done; cycle numbers count edges from the request.
  task automatic serve(input logic [7:0] lo, input logic [7:0] hi,
                       output int c1_at, output int done_at,
                       output logic [12:0] a_lo, output logic [12:0] a_hi,
                       output logic bank);
    c1_at = -1; done_at = -1; a_lo = '1; a_hi = '1; bank = 1'b0;
    for (int k = 1; k <= 30 && done_at < 0; k++) begin
      tick();
      if (sprite_fetch_c1 && c1_at < 0) c1_at = k;
      if (vram_rd) begin
        vram_data = vram_addr[0] ? hi : lo;
        if (vram_addr[0]) a_hi = vram_addr; else a_lo = vram_addr;
        bank = vram_bank;
      end
      if (sprite_fetch_done) done_at = k;
    end
    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL serve_timeout: done never seen, got none within 30 cycles, want one");
    end
  endtask

  task automatic wait_rd(input logic plane, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      if (vram_rd && vram_addr[0] == plane) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_rd: plane %0d read not reached within 20 cycles", plane);
    end
  endtask

  task automatic pop_check(input string name, input logic [15:0] cols, input logic [2:0] pal);
    logic [1:0] ec;
    logic [2:0] ep;
    for (int i = 0; i < 8; i++) begin
      ec = cols[2*i +: 2];
      ep = (ec != 2'd0) ? pal : 3'd0;
      total++;
      if ({spr_pix_color, spr_pix_pal} !== {ec, ep}) begin
        bad++;
        $display("FAIL %s pix%0d: got col=%0d pal=%0d want col=%0d pal=%0d",
                 name, i, spr_pix_color, spr_pix_pal, ec, ep);
      end
      shift = 1'b1;
      tick();
      shift = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; isGBC = 1'b0; lcd_on = 1'b1; line_reset = 1'b0;
    sprite_fetch = 1'b0; sprite_addr = '0; sprite_attr = '0; sprite_index = '0;
    vram_data = '0; shift = 1'b0;
    tick(); tick();
    total++;
    if ({sprite_fetch_c1, sprite_fetch_done, sprite_busy, vram_rd, vram_addr, vram_bank,
         spr_pix_color, spr_pix_pal, spr_pix_prio} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got c1=%0b done=%0b busy=%0b rd=%0b addr=%h bank=%0b col=%0d pal=%0d prio=%0b, want all 0",
               sprite_fetch_c1, sprite_fetch_done, sprite_busy, vram_rd, vram_addr, vram_bank,
               spr_pix_color, spr_pix_pal, spr_pix_prio);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dmg_basic();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank;
    sprite_addr = 11'h010; sprite_attr = 8'h00; sprite_index = 4'd0; sprite_fetch = 1'b1;
    serve(8'h80, 8'h01, c1_at, done_at, a_lo, a_hi, bank);
    total++;
    if (c1_at !== 1) begin bad++; $display("FAIL basic_c1: got cycle %0d want 1", c1_at); end
    total++;
    if (done_at - c1_at !== 6) begin bad++; $display("FAIL basic_latency: got c1->done %0d want 6", done_at - c1_at); end
    total++;
    if (a_lo !== 13'h020) begin bad++; $display("FAIL basic_addr_lo: got %h want 020", a_lo); end
    total++;
    if (a_hi !== 13'h021) begin bad++; $display("FAIL basic_addr_hi: got %h want 021", a_hi); end
    sprite_fetch = 1'b0;
    tick();
    total++;
    if (sprite_busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got busy=%0b want 0", sprite_busy); end
    pop_check("basic", 16'h8001, 3'd0);
  endtask

  task automatic test_xflip();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank;
    sprite_addr = 11'h010; sprite_attr = 8'hB0; sprite_index = 4'd0; sprite_fetch = 1'b1;
    serve(8'h80, 8'h01, c1_at, done_at, a_lo, a_hi, bank);
    sprite_fetch = 1'b0;
    tick();
    total++;
    if (spr_pix_prio !== 1'b1) begin bad++; $display("FAIL xflip_prio: got %0b want 1", spr_pix_prio); end
    pop_check("xflip", 16'h4002, 3'd1);
  endtask

  task automatic test_back_to_back_dmg();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank;
    isGBC = 1'b0;
    sprite_addr = 11'h020; sprite_attr = 8'h00; sprite_index = 4'd0; sprite_fetch = 1'b1;
    serve(8'hFF, 8'h00, c1_at, done_at, a_lo, a_hi, bank);
    sprite_addr = 11'h030; sprite_index = 4'd1;
    serve(8'hFF, 8'hFF, c1_at, done_at, a_lo, a_hi, bank);
    total++;
    if (c1_at !== 2) begin bad++; $display("FAIL b2b_gap: got second c1 at %0d want 2", c1_at); end
    total++;
    if (a_lo !== 13'h060) begin bad++; $display("FAIL b2b_addr: got %h want 060", a_lo); end
    sprite_fetch = 1'b0;
    tick();
    pop_check("dmg_overlap", 16'h5555, 3'd0);
  endtask

  task automatic test_cgb_overlap();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank;
    isGBC = 1'b1;
    sprite_addr = 11'h040; sprite_attr = 8'h0D; sprite_index = 4'd3; sprite_fetch = 1'b1;
    serve(8'h00, 8'hFF, c1_at, done_at, a_lo, a_hi, bank);
    total++;
    if (bank !== 1'b1) begin bad++; $display("FAIL cgb_bank: got %0b want 1", bank); end
    sprite_addr = 11'h050; sprite_attr = 8'h02; sprite_index = 4'd1;
    serve(8'hFF, 8'h00, c1_at, done_at, a_lo, a_hi, bank);
    sprite_fetch = 1'b0;
    tick();
    pop_check("cgb_overlap", 16'h5555, 3'd2);
    isGBC = 1'b0;
  endtask

  task automatic test_abort();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank, ok, seen;
    sprite_addr = 11'h060; sprite_attr = 8'h00; sprite_index = 4'd0; sprite_fetch = 1'b1;
    serve(8'hAA, 8'h00, c1_at, done_at, a_lo, a_hi, bank);
    sprite_fetch = 1'b0;
    tick();
    sprite_addr = 11'h070; sprite_index = 4'd2; vram_data = 8'hFF; sprite_fetch = 1'b1;
    wait_rd(1'b1, ok);
    sprite_fetch = 1'b0;
    tick();
    total++;
    if ({vram_rd, sprite_busy, sprite_fetch_done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle: got rd=%0b busy=%0b done=%0b want 000", vram_rd, sprite_busy, sprite_fetch_done);
    end
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (sprite_fetch_done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_done: got done=1 want 0"); end
    pop_check("abort_fifo", 16'h1111, 3'd0);
  endtask

  task automatic test_reset_mid_fetch();
    int c1_at, done_at;
    logic [12:0] a_lo, a_hi;
    logic bank, ok;
    sprite_addr = 11'h080; sprite_attr = 8'h00; sprite_index = 4'd0; sprite_fetch = 1'b1;
    serve(8'hFF, 8'hFF, c1_at, done_at, a_lo, a_hi, bank);
    wait_rd(1'b0, ok);
    ce = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({vram_rd, vram_addr} !== {1'b1, 13'h100}) begin
      bad++;
      $display("FAIL ce_hold: got rd=%0b addr=%h want rd=1 addr=100", vram_rd, vram_addr);
    end
    #2 reset = 1'b1; sprite_fetch = 1'b0;
    #1;
    total++;
    if ({vram_rd, sprite_busy, spr_pix_color} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got rd=%0b busy=%0b col=%0d want 0 0 0", vram_rd, sprite_busy, spr_pix_color);
    end
    #1 reset = 1'b0;
    ce = 1'b1;
    tick();
    sprite_fetch = 1'b1;
    serve(8'hFF, 8'hFF, c1_at, done_at, a_lo, a_hi, bank);
    wait_rd(1'b0, ok);
    ce = 1'b0; line_reset = 1'b1; sprite_fetch = 1'b0;
    tick();
    total++;
    if ({vram_rd, spr_pix_color} !== 3'b111) begin
      bad++;
      $display("FAIL line_reset_no_ce: got rd=%0b col=%0d want rd=1 col=3", vram_rd, spr_pix_color);
    end
    ce = 1'b1;
    tick();
    total++;
    if ({vram_rd, sprite_busy, spr_pix_color} !== 4'b0000) begin
      bad++;
      $display("FAIL line_reset: got rd=%0b busy=%0b col=%0d want 0 0 0", vram_rd, sprite_busy, spr_pix_color);
    end
    line_reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_dmg_basic();
    test_xflip();
    test_back_to_back_dmg();
    test_cgb_overlap();
    test_abort();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
